// File: rtl/mpi_reduce_pkg.sv
// Shared types and constants for the element-wise reduction stage.
package mpi_reduce_pkg;

  localparam int DATA_W    = 512;
  localparam int LANE_W    = 32;
  localparam int NUM_LANES = DATA_W / LANE_W;

  // Per-lane operation; encoding matches the op_mode input.
  typedef enum logic [1:0] {
    OP_SUM  = 2'd0,
    OP_MAX  = 2'd1,
    OP_MIN  = 2'd2,
    OP_PASS = 2'd3
  } reduce_op_t;

endpackage

// File: rtl/mpi_reduce_sum_stage_if.sv
// AXI-Stream style bundle (valid/ready/data/keep/last) used for both
// operand inputs and the reduced output.
interface mpi_reduce_sum_stage_if #(
  parameter int DATA_W = 512
);
  logic                  valid;
  logic                  ready;
  logic [DATA_W-1:0]     data;
  logic [DATA_W/8-1:0]   keep;
  logic                  last;

  modport master (output valid, output data, output keep, output last, input ready);
  modport slave  (input valid, input data, input keep, input last, output ready);
endinterface

// File: rtl/reduce_lane_op.sv
// One 32-bit reduction lane: wrapping add, signed max/min (ties pick A)
// or pass-through. Lanes with incomplete keep pass A unchanged.
module reduce_lane_op
  import mpi_reduce_pkg::*;
#(
  parameter int W = LANE_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  reduce_op_t   op,
  input  logic         lane_keep_ok,
  output logic [W-1:0] result
);

  // Select the lane result from the sampled operation
  always_comb begin
    result = a;
    if (lane_keep_ok) begin
      case (op)
        OP_SUM:  result = a + b;
        OP_MAX:  result = ($signed(a) >= $signed(b)) ? a : b;
        OP_MIN:  result = ($signed(a) <= $signed(b)) ? a : b;
        default: result = a;
      endcase
    end
  end

endmodule

// File: rtl/mpi_reduce_sum_stage.sv
// Joins operand streams A (local) and B (remote) beat-by-beat, reduces
// each 32-bit lane, and emits the result through a 2-stage pipeline.
// Also tracks beat/packet counts and sticky alignment errors.
module mpi_reduce_sum_stage #(
  parameter int DATA_W = 512,
  parameter int LANE_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             op_mode,
  input  logic                   clear,
  mpi_reduce_sum_stage_if.slave  s_a,
  mpi_reduce_sum_stage_if.slave  s_b,
  mpi_reduce_sum_stage_if.master m,
  output logic [CNT_W-1:0]       beat_cnt,
  output logic [CNT_W-1:0]       pkt_cnt,
  output logic                   err_last,
  output logic                   err_keep
);
  import mpi_reduce_pkg::*;

  localparam int NL  = DATA_W / LANE_W;
  localparam int KW  = DATA_W / 8;
  localparam int LKW = LANE_W / 8;

  // Stage 1: joined operands and the mode sampled at acceptance
  logic              st1_valid_reg;
  logic [DATA_W-1:0] st1_a_reg;
  logic [DATA_W-1:0] st1_b_reg;
  logic [KW-1:0]     st1_keep_reg;
  logic              st1_last_reg;
  reduce_op_t        st1_op_reg;

  // Stage 2: reduced result presented on m
  logic              st2_valid_reg;
  logic [DATA_W-1:0] st2_data_reg;
  logic [KW-1:0]     st2_keep_reg;
  logic              st2_last_reg;

  logic [CNT_W-1:0]  beat_cnt_reg;
  logic [CNT_W-1:0]  pkt_cnt_reg;
  logic              err_last_reg;
  logic              err_keep_reg;

  logic              st2_en;
  logic              adv;
  logic              accept;
  logic [NL-1:0]     lane_ok;
  logic [DATA_W-1:0] lane_res;

  // ST2 may load when empty or its beat is leaving this cycle; ST1 may
  // load when empty or when it can hand its beat to ST2.
  assign st2_en = !st2_valid_reg || m.ready;
  assign adv    = !st1_valid_reg || st2_en;

  // Each side is ready only when the other side is offering a beat, so
  // beats are always consumed in pairs.
  assign s_a.ready = s_b.valid && adv && !rst;
  assign s_b.ready = s_a.valid && adv && !rst;
  assign accept    = s_a.valid && s_b.valid && adv && !rst;

  // Stage 1 register: capture the joined beat
  always_ff @(posedge clk) begin
    if (rst) begin
      st1_valid_reg <= 1'b0;
      st1_a_reg     <= '0;
      st1_b_reg     <= '0;
      st1_keep_reg  <= '0;
      st1_last_reg  <= 1'b0;
      st1_op_reg    <= OP_SUM;
    end else if (adv) begin
      st1_valid_reg <= accept;
      if (accept) begin
        st1_a_reg    <= s_a.data;
        st1_b_reg    <= s_b.data;
        st1_keep_reg <= s_a.keep & s_b.keep;
        st1_last_reg <= s_a.last | s_b.last;
        st1_op_reg   <= reduce_op_t'(op_mode);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
      assign lane_ok[gi] = &st1_keep_reg[gi*LKW +: LKW];

      reduce_lane_op #(
        .W(LANE_W)
      ) u_lane (
        .a            (st1_a_reg[gi*LANE_W +: LANE_W]),
        .b            (st1_b_reg[gi*LANE_W +: LANE_W]),
        .op           (st1_op_reg),
        .lane_keep_ok (lane_ok[gi]),
        .result       (lane_res[gi*LANE_W +: LANE_W])
      );
    end
  endgenerate

  // Stage 2 register: hold the result while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      st2_valid_reg <= 1'b0;
      st2_data_reg  <= '0;
      st2_keep_reg  <= '0;
      st2_last_reg  <= 1'b0;
    end else if (st2_en) begin
      st2_valid_reg <= st1_valid_reg;
      if (st1_valid_reg) begin
        st2_data_reg <= lane_res;
        st2_keep_reg <= st1_keep_reg;
        st2_last_reg <= st1_last_reg;
      end
    end
  end

  // Status counters and sticky errors; clear overrides a same-cycle update
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      beat_cnt_reg <= '0;
      pkt_cnt_reg  <= '0;
      err_last_reg <= 1'b0;
      err_keep_reg <= 1'b0;
    end else if (accept) begin
      beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
      if (s_a.last || s_b.last) begin
        pkt_cnt_reg <= pkt_cnt_reg + CNT_W'(1);
      end
      if (s_a.last != s_b.last) begin
        err_last_reg <= 1'b1;
      end
      if (s_a.keep != s_b.keep) begin
        err_keep_reg <= 1'b1;
      end
    end
  end

  assign m.valid  = st2_valid_reg;
  assign m.data   = st2_data_reg;
  assign m.keep   = st2_keep_reg;
  assign m.last   = st2_last_reg;

  assign beat_cnt = beat_cnt_reg;
  assign pkt_cnt  = pkt_cnt_reg;
  assign err_last = err_last_reg;
  assign err_keep = err_keep_reg;

endmodule

// File: tb/tb_mpi_reduce_sum_stage.sv
// Self-checking bench for mpi_reduce_sum_stage: directed scenarios plus a
// randomized backpressure run checked against a lane-arithmetic model.
module tb_mpi_reduce_sum_stage;

  localparam int DW = 512;
  localparam int KW = DW / 8;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [1:0]  op_mode;
  logic [31:0] beat_cnt;
  logic [31:0] pkt_cnt;
  logic        err_last;
  logic        err_keep;

  mpi_reduce_sum_stage_if #(.DATA_W(DW)) a_if ();
  mpi_reduce_sum_stage_if #(.DATA_W(DW)) b_if ();
  mpi_reduce_sum_stage_if #(.DATA_W(DW)) m_if ();

  mpi_reduce_sum_stage #(.DATA_W(DW), .LANE_W(32), .CNT_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_mode  (op_mode),
    .clear    (clear),
    .s_a      (a_if),
    .s_b      (b_if),
    .m        (m_if),
    .beat_cnt (beat_cnt),
    .pkt_cnt  (pkt_cnt),
    .err_last (err_last),
    .err_keep (err_keep)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  beat_t         exp_q[$];
  int            cyc = 0;
  int            acc_cnt = 0;
  int            out_cnt = 0;
  int            out_last_cnt = 0;
  int            first_acc = -1;
  int            first_mv = -1;
  logic          acc_flag = 1'b0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data;
  logic [DW-1:0] last_out_data;
  logic [31:0]   mdl_beats = 0;
  logic [31:0]   mdl_pkts = 0;
  logic          mdl_err_last = 1'b0;
  logic          mdl_err_keep = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: per-lane integer arithmetic on the joined beat
  function automatic logic [DW-1:0] reduce_model(input logic [1:0] op, input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b, input logic [KW-1:0] ka,
                                                 input logic [KW-1:0] kb);
    logic [DW-1:0] r;
    logic [KW-1:0] k;
    k = ka & kb;
    for (int i = 0; i < DW / 32; i++) begin
      int x;
      int y;
      int z;
      x = a[32*i +: 32];
      y = b[32*i +: 32];
      case (op)
        2'd0:    z = x + y;
        2'd1:    z = (x >= y) ? x : y;
        2'd2:    z = (x <= y) ? x : y;
        default: z = x;
      endcase
      if (k[4*i +: 4] != 4'hF) z = x;
      r[32*i +: 32] = z;
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // One clock: observe handshakes just before the edge, update model, advance
  task automatic step();
    logic  ofire;
    beat_t e;
    #1;
    acc_flag = a_if.valid && a_if.ready && !rst;
    ofire    = m_if.valid && m_if.ready && !rst;
    if (stall_prev && !rst) chk("stall_hold", m_if.data, stall_data);
    if (rst) begin
      exp_q.delete();
      mdl_beats = 0;
      mdl_pkts = 0;
      mdl_err_last = 1'b0;
      mdl_err_keep = 1'b0;
    end else begin
      if (ofire) begin
        out_cnt++;
        last_out_data = m_if.data;
        if (m_if.last) out_last_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", m_if.data, e.data);
          chk("out_keep", m_if.keep, e.keep);
          chk("out_last", m_if.last, e.last);
        end
      end
      if (acc_flag) begin
        acc_cnt++;
        e.data = reduce_model(op_mode, a_if.data, b_if.data, a_if.keep, b_if.keep);
        e.keep = a_if.keep & b_if.keep;
        e.last = a_if.last | b_if.last;
        exp_q.push_back(e);
        mdl_beats = mdl_beats + 1;
        if (e.last) mdl_pkts = mdl_pkts + 1;
        if (a_if.last != b_if.last) mdl_err_last = 1'b1;
        if (a_if.keep != b_if.keep) mdl_err_keep = 1'b1;
      end
      if (clear) begin
        mdl_beats = 0;
        mdl_pkts = 0;
        mdl_err_last = 1'b0;
        mdl_err_keep = 1'b0;
      end
    end
    if (acc_flag && first_acc < 0) first_acc = cyc;
    if (m_if.valid && !rst && first_mv < 0) first_mv = cyc;
    stall_prev = m_if.valid && !m_if.ready && !rst;
    stall_data = m_if.data;
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [KW-1:0] ka,
                       input logic [KW-1:0] kb, input logic la, input logic lb);
    a_if.valid = 1'b1; a_if.data = a; a_if.keep = ka; a_if.last = la;
    b_if.valid = 1'b1; b_if.data = b; b_if.keep = kb; b_if.last = lb;
  endtask

  task automatic stop_inputs();
    a_if.valid = 1'b0; b_if.valid = 1'b0; a_if.last = 1'b0; b_if.last = 1'b0;
  endtask

  task automatic drain();
    stop_inputs();
    m_if.ready = 1'b1;
    for (int g = 0; g < 200 && exp_q.size() > 0; g++) step();
    step();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_beat_cnt"}, beat_cnt, mdl_beats);
    chk({tag, "_pkt_cnt"}, pkt_cnt, mdl_pkts);
    chk({tag, "_err_last"}, err_last, mdl_err_last);
    chk({tag, "_err_keep"}, err_keep, mdl_err_keep);
  endtask

  task automatic one_beat(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [KW-1:0] kb, output logic [DW-1:0] res);
    op_mode = op;
    drive(a, b, '1, kb, 1'b1, 1'b1);
    m_if.ready = 1'b1;
    for (int g = 0; g < 20; g++) begin
      step();
      if (acc_flag) break;
    end
    chk("single_accept", acc_flag, 1);
    drain();
    res = last_out_data;
  endtask

  initial begin : main
    logic [DW-1:0] va;
    logic [DW-1:0] vb;
    logic [DW-1:0] vr;
    logic [DW-1:0] vexp;
    logic [KW-1:0] kk;
    logic          lr;
    int            start_acc;
    int            start_out;

    rst = 1'b1; clear = 1'b0; op_mode = 2'd0;
    drive('0, '0, '1, '1, 1'b0, 1'b0);
    m_if.ready = 1'b1;
    @(negedge clk);
    repeat (3) step();
    chk("rst_a_ready", a_if.ready, 0);
    chk("rst_b_ready", b_if.ready, 0);
    stop_inputs();
    rst = 1'b0;
    chk("rst_m_valid", m_if.valid, 0);
    chk("rst_m_data", m_if.data, 0);
    chk("rst_m_keep", m_if.keep, 0);
    chk("rst_m_last", m_if.last, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_err_last", err_last, 0);
    chk("rst_err_keep", err_keep, 0);
    step();

    // SUM basic: 64 beats, one packet
    va = {16{32'h000011aa}};
    vb = {16{32'h000033aa}};
    first_acc = -1; first_mv = -1; start_out = out_cnt; out_last_cnt = 0;
    op_mode = 2'd0;
    for (int i = 1; i <= 64; i++) begin
      drive(va, vb, '1, '1, i == 64, i == 64);
      step();
      if (i == 1) chk("sum_first_accept", acc_flag, 1);
    end
    drain();
    vexp = {16{32'h00004554}};
    chk("sum_out_count", out_cnt - start_out, 64);
    chk("sum_last_count", out_last_cnt, 1);
    chk("sum_value", last_out_data, vexp);
    chk("sum_latency", first_mv - first_acc, 2);
    chk("sum_beat_cnt", beat_cnt, 64);
    chk("sum_pkt_cnt", pkt_cnt, 1);
    check_status("sum");

    // Wrap and signed operations
    va = {16{32'hFFFFFFFF}}; vb = {16{32'h00000002}};
    one_beat(2'd0, va, vb, '1, vr);
    vexp = {16{32'h00000001}};
    chk("sum_wrap", vr, vexp);
    one_beat(2'd1, va, vb, '1, vr);
    vexp = {16{32'h00000002}};
    chk("max_signed", vr, vexp);
    va = {16{32'hFFFFFFFB}}; vb = {16{32'h00000003}};
    one_beat(2'd2, va, vb, '1, vr);
    vexp = {16{32'hFFFFFFFB}};
    chk("min_signed", vr, vexp);
    va = {16{32'h00000007}};
    one_beat(2'd1, va, va, '1, vr);
    vexp = {16{32'h00000007}};
    chk("max_tie", vr, vexp);
    va = rand_data(); vb = rand_data();
    one_beat(2'd3, va, vb, '1, vr);
    chk("pass_a", vr, va);

    // Randomized valids, 30% m_ready, mode changing per beat
    clear = 1'b1; step(); clear = 1'b0;
    start_acc = acc_cnt;
    for (int g = 0; g < 20000 && (acc_cnt - start_acc) < 256; g++) begin
      kk = ($urandom_range(0, 7) == 0) ? KW'({$urandom, $urandom}) : '1;
      lr = ($urandom_range(0, 7) == 0);
      drive(rand_data(), rand_data(), kk, kk, lr, lr);
      a_if.valid = $urandom_range(0, 1);
      b_if.valid = $urandom_range(0, 1);
      op_mode = 2'($urandom_range(0, 3));
      m_if.ready = ($urandom_range(0, 99) < 30);
      step();
    end
    chk("bp_accepted", acc_cnt - start_acc, 256);
    drain();
    chk("bp_beat_cnt", beat_cnt, 256);
    check_status("bp");

    // Misaligned last: A on beat 3, B on beat 4
    clear = 1'b1; step(); clear = 1'b0;
    op_mode = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      drive(rand_data(), rand_data(), '1, '1, i == 3, i == 4);
      step();
      if (i == 2) chk("err_last_before", err_last, 0);
      if (i >= 3) chk("err_last_set", err_last, 1);
    end
    drain();
    repeat (3) step();
    chk("err_last_sticky", err_last, 1);
    check_status("misalign");
    clear = 1'b1; step(); clear = 1'b0;
    chk("err_last_cleared", err_last, 0);

    // Keep mismatch on lane 0
    va = rand_data(); vb = rand_data();
    kk = '1; kk[3:0] = 4'h0;
    one_beat(2'd0, va, vb, kk, vr);
    chk("err_keep_set", err_keep, 1);
    chk("keep_lane0_is_a", vr[31:0], va[31:0]);
    vexp = va + 0;
    vexp[63:32] = va[63:32] + vb[63:32];
    chk("keep_lane1_sum", vr[63:32], vexp[63:32]);
    check_status("keep");

    // One-sided valid never consumes
    start_acc = acc_cnt;
    a_if.valid = 1'b1; b_if.valid = 1'b0; m_if.ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("one_sided_a_ready", a_if.ready, 0);
      chk("one_sided_m_valid", m_if.valid, 0);
      step();
    end
    stop_inputs();
    chk("one_sided_accepts", acc_cnt - start_acc, 0);
    check_status("one_sided");

    // Reset with two beats in flight
    m_if.ready = 1'b0;
    drive(rand_data(), rand_data(), '1, '1, 1'b0, 1'b0);
    step(); step();
    stop_inputs();
    chk("pre_rst_m_valid", m_if.valid, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("flush_m_valid", m_if.valid, 0);
    chk("flush_beat_cnt", beat_cnt, 0);
    chk("flush_pkt_cnt", pkt_cnt, 0);
    m_if.ready = 1'b1;
    repeat (4) step();
    chk("flush_no_output", m_if.valid, 0);

    // Clear coincident with an accepted beat
    drive(rand_data(), rand_data(), '1, '1, 1'b1, 1'b1);
    clear = 1'b1; step(); clear = 1'b0;
    chk("clear_win_accept", acc_flag, 1);
    chk("clear_win_beat_cnt", beat_cnt, 0);
    drive(rand_data(), rand_data(), '1, '1, 1'b0, 1'b0);
    step();
    drain();
    chk("after_clear_beat_cnt", beat_cnt, 1);
    check_status("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpi_reduce_sum_stage.md
Name: mpi_reduce_sum_stage

Overview:
- Element-wise reduction datapath that sits directly downstream of mpi_reduce_control.
- Joins two 512-bit AXI-Stream inputs beat-by-beat and applies a per-lane 32-bit operation (SUM/MAX/MIN):
  - A = local operand read over DMA;
  - B = remote partial received over TCP.
- Emits the reduced stream toward the TCP tx data path.
- Checks that the two inputs stay aligned and keeps beat/packet counters for status_reg.

Parameters:
- DATA_W, 512, stream data width in bits
- LANE_W, 32, reduction element width in bits; DATA_W/LANE_W lanes (16)
- CNT_W, 32, width of the status counters

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- op_mode  in  2  0=SUM (signed, wraps), 1=MAX signed, 2=MIN signed, 3=pass A
- clear  in  1  one-cycle pulse; clears counters and sticky errors
- s_a_valid / s_a_ready  in/out  1/1  operand A handshake
- s_a_data  in  DATA_W  operand A
- s_a_keep  in  DATA_W/8  operand A byte keep
- s_a_last  in  1  operand A end of packet
- s_b_valid / s_b_ready / s_b_data / s_b_keep / s_b_last  same widths  operand B stream
- m_valid / m_ready  out/in  1/1  result handshake
- m_data  out  DATA_W  reduced data
- m_keep  out  DATA_W/8  result keep
- m_last  out  1  result end of packet
- beat_cnt  out  CNT_W  beats accepted since reset/clear
- pkt_cnt  out  CNT_W  packets (last beats) accepted
- err_last  out  1  sticky: s_a_last != s_b_last on a joined beat
- err_keep  out  1  sticky: s_a_keep != s_b_keep on a joined beat

Behaviour:
- Reset:
  - all valids 0, all counters 0, err flags 0;
  - m_data, m_keep and m_last are 0.
- Join:
  - A beat is accepted only when s_a_valid & s_b_valid & adv.
  - adv = !st1_valid | !st2_valid | m_ready (the pipeline can move).
  - s_a_ready = s_b_valid & adv; s_b_ready = s_a_valid & adv.
  - Ready never asserts on one side alone; no beat is consumed singly.
- Pipeline: 2 register stages.
  - ST1 registers A, B, keep and last, and op_mode sampled at acceptance.
  - ST2 registers the lane results.
  - Latency from accepted beat to m_valid is 2 cycles when unstalled; throughput is 1 beat/cycle.
  - A stall (m_valid & !m_ready) holds ST2. ST1 advances into ST2 only if ST2 is empty or draining. No bubble insertion, no data loss, m_data stable while stalled.
- Lane op for each lane i (bits [LANE_W*i +: LANE_W]):
  - SUM: a+b mod 2^32.
  - MAX/MIN: signed compare; on a tie, A is selected.
  - Pass A: output = a.
- Keep handling:
  - m_keep = A_keep & B_keep.
  - A lane whose 4 keep bits in that AND are not all 1 outputs A's lane bits unchanged.
- Last: m_last = A_last | B_last.
- Errors:
  - err_last is set when a joined beat has A_last != B_last.
  - err_keep is set when a joined beat has A_keep != B_keep.
  - Both are sticky and cleared only by clear or rst.
- Counters:
  - beat_cnt increments on each accepted beat; pkt_cnt increments on each accepted beat with m_last-equivalent (A_last|B_last).
  - Both wrap at 2^CNT_W.
  - clear in the same cycle as an increment: clear wins, and the counter reads 0 the next cycle.
- op_mode change mid-packet: takes effect on the next accepted beat; beats in flight keep their sampled mode.
- rst mid-packet: pipeline flushed and in-flight beats discarded; readys are 0 during rst.

Decomposition:
- Package mpi_reduce_pkg:
  - typedef reduce_op_t (SUM/MAX/MIN/PASS);
  - constants LANE_W, NUM_LANES = DATA_W/LANE_W.
- Sub-module reduce_lane_op:
  - combinational, one lane;
  - inputs a, b, op, lane_keep_ok; output result;
  - instantiated NUM_LANES times in a generate loop.

Test Plan:
- SUM basic: each lane A=0x000011aa, B=0x000033aa, 64 beats, last on beat 64, m_ready=1 -> 64 output beats, each lane 0x00004554, m_last on beat 64 only, beat_cnt=64, pkt_cnt=1, no errors, first m_valid 2 cycles after first accept.
- Wrap/signed ops:
  - lane A=0xFFFFFFFF, B=0x00000002: SUM -> 0x00000001.
  - MAX with A=0xFFFFFFFF (-1), B=0x00000002 -> 0x00000002.
  - MIN with A=-5, B=3 -> 0xFFFFFFFB.
  - MAX with A=B=7 -> 7.
- Backpressure: random m_ready at 30% duty over 256 beats with A/B valids independently randomized -> output sequence equals golden model, m_data stable whenever m_valid & !m_ready, beat_cnt=256.
- Misalignment: A_last on beat 3, B_last on beat 4 -> err_last=1 from the cycle after beat 3 is accepted; it remains 1 until clear pulse, then 0. Keep mismatch on lane 0 (A_keep=all ones, B_keep bits[3:0]=0) -> err_keep=1, and output lane 0 equals A lane 0.
- One-sided valid: s_a_valid=1 for 10 cycles with s_b_valid=0 -> s_a_ready stays 0, beat_cnt unchanged, m_valid stays 0.
- Reset/clear: rst asserted with 2 beats in the pipeline -> m_valid=0 and counters=0 the next cycle. clear coincident with an accepted beat -> beat_cnt=0 the next cycle.
